// File: rtl/sgm_pkg.sv
// sgm_pkg: 7-segment pattern constants (bit6=a .. bit0=g) and capture FSM states.
package sgm_pkg;
    localparam logic [6:0] SGM_0     = 7'b1111110;
    localparam logic [6:0] SGM_1     = 7'b0110000;
    localparam logic [6:0] SGM_2     = 7'b1101101;
    localparam logic [6:0] SGM_3     = 7'b1111001;
    localparam logic [6:0] SGM_4     = 7'b0110011;
    localparam logic [6:0] SGM_5     = 7'b1011011;
    localparam logic [6:0] SGM_6     = 7'b1011111;
    localparam logic [6:0] SGM_7     = 7'b1110000;
    localparam logic [6:0] SGM_8     = 7'b1111111;
    localparam logic [6:0] SGM_9     = 7'b1111011;
    localparam logic [6:0] SGM_BLANK = 7'b0000000;
    localparam logic [6:0] SGM_HEX_A = 7'b1110111;
    localparam logic [6:0] SGM_HEX_B = 7'b0011111;
    localparam logic [6:0] SGM_HEX_C = 7'b1001110;
    localparam logic [6:0] SGM_HEX_D = 7'b0111101;
    localparam logic [6:0] SGM_HEX_E = 7'b1001111;
    localparam logic [6:0] SGM_HEX_F = 7'b1000111;
    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
endpackage

// File: rtl/sgm_bcd_capture_if.sv
// sgm_bcd_capture_if: multiplexed display bus in, captured digits out.
interface sgm_bcd_capture_if #(parameter int N_DIGITS = 4);
    logic [6:0]            sgm;
    logic [N_DIGITS-1:0]   dig_en;
    logic [4*N_DIGITS-1:0] bcd_flat;
    logic [N_DIGITS-1:0]   digit_valid;
    logic [N_DIGITS-1:0]   digit_err;
    logic                  upd;
    logic [2:0]            upd_idx;
    modport master (output sgm, dig_en, input bcd_flat, digit_valid, digit_err, upd, upd_idx);
    modport slave  (input sgm, dig_en, output bcd_flat, digit_valid, digit_err, upd, upd_idx);
endinterface

// File: rtl/sgm_bcd_dec.sv
// sgm_bcd_dec: combinational 7-segment to BCD decode; SGM_HEX_EN adds A..F as legal digits.
module sgm_bcd_dec
    import sgm_pkg::*;
(
    input  logic [6:0] sgm_i,
    output logic [3:0] bcd_o,
    output logic       is_legal_o,
    output logic       is_blank_o
);
    assign is_blank_o = (sgm_i == SGM_BLANK);
    always_comb begin
        bcd_o      = 4'h0;
        is_legal_o = 1'b1;
        case (sgm_i)
            SGM_0: bcd_o = 4'h0;
            SGM_1: bcd_o = 4'h1;
            SGM_2: bcd_o = 4'h2;
            SGM_3: bcd_o = 4'h3;
            SGM_4: bcd_o = 4'h4;
            SGM_5: bcd_o = 4'h5;
            SGM_6: bcd_o = 4'h6;
            SGM_7: bcd_o = 4'h7;
            SGM_8: bcd_o = 4'h8;
            SGM_9: bcd_o = 4'h9;
`ifdef SGM_HEX_EN
            SGM_HEX_A: bcd_o = 4'hA;
            SGM_HEX_B: bcd_o = 4'hB;
            SGM_HEX_C: bcd_o = 4'hC;
            SGM_HEX_D: bcd_o = 4'hD;
            SGM_HEX_E: bcd_o = 4'hE;
            SGM_HEX_F: bcd_o = 4'hF;
`endif
            default: is_legal_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/sgm_bcd_capture.sv
// sgm_bcd_capture: commits a digit slot once {sgm, dig_en} has held for STABLE_CYCLES samples.
// Hex digits A..F are accepted only when SGM_HEX_EN is defined.
module sgm_bcd_capture
    import sgm_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input logic clk,
    input logic rst_n,
    sgm_bcd_capture_if.slave bus
);
    localparam int PW = 7 + N_DIGITS;
    logic [PW-1:0]             samp_q, pair_d;
    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [N_DIGITS-1:0][3:0]  bcd_q;
    logic [N_DIGITS-1:0]       valid_q, err_q;
    logic                      upd_q;
    logic [2:0]                idx_q, idx_d;
    logic [3:0]                dec_bcd;
    logic                      dec_legal, dec_blank, hot, match;

    sgm_bcd_dec u_dec (.sgm_i(bus.sgm), .bcd_o(dec_bcd), .is_legal_o(dec_legal), .is_blank_o(dec_blank));

    assign pair_d = {bus.sgm, bus.dig_en};
    assign hot    = $onehot(bus.dig_en);
    assign match  = (pair_d == samp_q);

    always_comb begin
        idx_d = 3'd0;
        for (int d = 0; d < N_DIGITS; d++)
            if (bus.dig_en[d]) idx_d = 3'(d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= '0;
            err_q   <= '0;
            upd_q   <= 1'b0;
            idx_q   <= 3'd0;
        end else begin
            samp_q <= pair_d;
            upd_q  <= 1'b0;
            case (state_q)
                IDLE: if (hot) begin
                    state_q <= SETTLE;
                    cnt_q   <= CNT_W'(1);
                end
                SETTLE: if (!hot) state_q <= IDLE;
                else if (!match) cnt_q <= CNT_W'(1);
                else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_q <= LOCKED;
                    upd_q   <= 1'b1;
                    idx_q   <= idx_d;
                    // dig_en is one-hot here, so exactly one slot is touched
                    for (int d = 0; d < N_DIGITS; d++)
                        if (bus.dig_en[d]) begin
                            valid_q[d] <= dec_legal;
                            err_q[d]   <= !dec_legal && !dec_blank;
                            if (dec_legal) bcd_q[d] <= dec_bcd;
                        end
                end else cnt_q <= cnt_q + 1'b1;
                LOCKED: if (!hot) state_q <= IDLE;
                else if (!match) begin
                    state_q <= SETTLE;
                    cnt_q   <= CNT_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bcd_flat    = bcd_q;
    assign bus.digit_valid = valid_q;
    assign bus.digit_err   = err_q;
    assign bus.upd         = upd_q;
    assign bus.upd_idx     = idx_q;
endmodule
